// File: rtl/dsd_rx_pkg.sv
// Shared definitions for the DSD serial path: receiver FSM states and the
// default word width / idle timeout used by both transmitter and receiver.
package dsd_rx_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } dsd_rx_state_t;

    localparam int DSD_DW_DEFAULT      = 16;
    localparam int DSD_TIMEOUT_DEFAULT = 64;
    localparam int DSD_SYNC_DEFAULT    = 2;

endpackage

// File: rtl/dsd_rx_sync.sv
// N-bit multi-flop synchroniser bank. All bits share the same depth so that
// signals launched together stay aligned after synchronisation.
module dsd_rx_sync #(
    parameter int N      = 3,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] stg [STAGES];

    // Shift the asynchronous inputs through STAGES flops; cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/dsd_rx.sv
// DSD serial receiver: oversamples dclk/ldata/rdata with bclk, deserialises
// MSB-first into DW-bit word pairs and flags loss of dclk activity.
module dsd_rx
    import dsd_rx_pkg::*;
#(
    parameter int DW          = DSD_DW_DEFAULT,
    parameter int TIMEOUT     = DSD_TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES = DSD_SYNC_DEFAULT
) (
    input  logic          bclk,
    input  logic          rst,
    input  logic          dclk,
    input  logic          ldata,
    input  logic          rdata,
    input  logic          align_i,
    output logic          valid_o,
    output logic [DW-1:0] ldata_o,
    output logic [DW-1:0] rdata_o,
    output logic          active_o
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] BCNT_LAST  = BW'(DW - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    dsd_rx_state_t state, state_next;

    logic [2:0]    sync_q;
    logic          dclk_s, ldata_s, rdata_s;
    logic          dclk_d;
    logic          edge_det;
    logic [BW-1:0] bcnt;
    logic [TW-1:0] timer;
    logic [DW-1:0] shift_l, shift_r;
    logic [DW-1:0] word_l, word_r;

    // Saturating increment: the idle timer must never wrap back to zero
    function automatic logic [TW-1:0] timer_sat_inc(input logic [TW-1:0] t);
        return (t == TIMER_LAST) ? t : t + TW'(1);
    endfunction

    dsd_rx_sync #(
        .N      (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (bclk),
        .rst (rst),
        .d   ({dclk, ldata, rdata}),
        .q   (sync_q)
    );

    assign dclk_s  = sync_q[2];
    assign ldata_s = sync_q[1];
    assign rdata_s = sync_q[0];

    // Delayed copy of synced dclk for rising-edge detection
    always_ff @(posedge bclk) begin
        if (rst) begin
            dclk_d <= 1'b0;
        end else begin
            dclk_d <= dclk_s;
        end
    end

    assign edge_det = dclk_s & ~dclk_d;

    // Words as they would look with the current sample shifted in
    assign word_l = {shift_l[DW-2:0], ldata_s};
    assign word_r = {shift_r[DW-2:0], rdata_s};

    // FSM state register
    always_ff @(posedge bclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: first edge wakes the link, a quiet TIMEOUT window idles it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (edge_det) state_next = ACTIVE;
            ACTIVE:  if (!edge_det && timer == TIMER_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        active_o = (state == ACTIVE);
    end

    // Deserialiser: shift registers, bit counter, idle timer and word outputs
    always_ff @(posedge bclk) begin
        if (rst) begin
            valid_o <= 1'b0;
            ldata_o <= '0;
            rdata_o <= '0;
            shift_l <= '0;
            shift_r <= '0;
            bcnt    <= '0;
            timer   <= '0;
        end else begin
            valid_o <= 1'b0;
            if (state == IDLE) begin
                timer <= '0;
                bcnt  <= '0;
                if (edge_det) begin
                    // First edge after idle is always the MSB of a new word
                    shift_l <= word_l;
                    shift_r <= word_r;
                    bcnt    <= BW'(1);
                end
            end else if (edge_det) begin
                timer   <= '0;
                shift_l <= word_l;
                shift_r <= word_r;
                if (bcnt == BCNT_LAST) begin
                    // A completing bit is always delivered, even with align_i
                    ldata_o <= word_l;
                    rdata_o <= word_r;
                    valid_o <= 1'b1;
                    bcnt    <= '0;
                end else if (align_i) begin
                    bcnt <= BW'(1);
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end else if (timer == TIMER_LAST) begin
                // Link went quiet: drop the partial word, keep last outputs
                timer <= '0;
                bcnt  <= '0;
            end else begin
                timer <= timer_sat_inc(timer);
                if (align_i) begin
                    bcnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsd_rx.sv
// Self-checking bench for dsd_rx (DW=16, TIMEOUT=64, SYNC_STAGES=2).
module tb_dsd_rx;

    localparam int DW          = 16;
    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        bit            jit;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;

    logic          bclk = 1'b0;
    logic          rst = 1'b1;
    logic          dclk = 1'b0;
    logic          ldata = 1'b0;
    logic          rdata = 1'b0;
    logic          align_i = 1'b0;
    logic          valid_o;
    logic [DW-1:0] ldata_o;
    logic [DW-1:0] rdata_o;
    logic          active_o;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    pair_t sbq[$];
    int    vt[$];
    vec_t  vecs[7];

    dsd_rx #(
        .DW          (DW),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .bclk     (bclk),
        .rst      (rst),
        .dclk     (dclk),
        .ldata    (ldata),
        .rdata    (rdata),
        .align_i  (align_i),
        .valid_o  (valid_o),
        .ldata_o  (ldata_o),
        .rdata_o  (rdata_o),
        .active_o (active_o)
    );

    always #5 bclk = ~bclk;

    always @(posedge bclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid_o pulse must match the oldest pending expectation
    always @(negedge bclk) begin
        if (!rst && valid_o) begin
            vt.push_back(cyc);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got l=%0h r=%0h expected no word", ldata_o, rdata_o);
            end else begin
                pair_t e;
                e = sbq.pop_front();
                chk("word_l", 32'(ldata_o), 32'(e.l));
                chk("word_r", 32'(rdata_o), 32'(e.r));
            end
        end
    end

    task automatic send_bit(input logic l, input logic r, input bit jit);
        int lo, hi;
        lo = jit ? int'($urandom_range(6, 4)) : 2;
        hi = jit ? int'($urandom_range(6, 4)) : 2;
        @(negedge bclk);
        dclk  = 1'b0;
        ldata = l;
        rdata = r;
        repeat (lo - 1) @(negedge bclk);
        @(negedge bclk);
        dclk = 1'b1;
        repeat (hi - 1) @(negedge bclk);
    endtask

    // Send bits [first..last] MSB-first; expectation pushed as bit 0 goes out
    task automatic send_word(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input int first, input int last, input bit jit,
                             input bit push, input logic [DW-1:0] el,
                             input logic [DW-1:0] er);
        for (int i = first; i >= last; i--) begin
            if (push && i == 0) begin
                pair_t p;
                p.l = el;
                p.r = er;
                sbq.push_back(p);
            end
            send_bit(l[i], r[i], jit);
        end
    endtask

    task automatic wait_empty(input string name, input int max_cyc);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < max_cyc) begin
            @(posedge bclk);
            n++;
        end
        @(negedge bclk);
        chk(name, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge bclk);
        rst = 1'b0;
        @(negedge bclk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ldata", 32'(ldata_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        chk("rst_active", 32'(active_o), 32'd0);
        repeat (4) @(negedge bclk);

        // Basic receive with exact active_o latency on the first bit
        dclk  = 1'b0;
        ldata = 1'b1;
        rdata = 1'b0;
        @(negedge bclk);
        @(negedge bclk);
        dclk = 1'b1;
        repeat (SYNC_STAGES) @(negedge bclk);
        chk("active_early", 32'(active_o), 32'd0);
        @(negedge bclk);
        chk("active_rise", 32'(active_o), 32'd1);
        send_word(16'hA5C3, 16'h3C5A, 14, 0, 1'b0, 1'b1, 16'hA5C3, 16'h3C5A);
        wait_empty("basic_drain", 20);

        // Vector table
        vecs[0] = '{16'h0001, 16'hFFFE, 1'b0, 16'h0001, 16'hFFFE};
        vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 16'h8000, 16'h7FFF};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
        for (int i = 3; i < 7; i++) begin
            logic [DW-1:0] a, b;
            a = DW'($urandom);
            b = DW'($urandom);
            vecs[i] = '{a, b, 1'b1, a, b};
        end

        // Back-to-back words at bclk/4: pulses exactly 64 cycles apart
        vt.delete();
        for (int i = 0; i < 3; i++) begin
            send_word(vecs[i].l, vecs[i].r, DW - 1, 0, vecs[i].jit, 1'b1,
                      vecs[i].exp_l, vecs[i].exp_r);
        end
        wait_empty("b2b_drain", 20);
        chk("b2b_count", 32'(vt.size()), 32'd3);
        if (vt.size() == 3) begin
            chk("b2b_gap1", 32'(vt[1] - vt[0]), 32'd64);
            chk("b2b_gap2", 32'(vt[2] - vt[1]), 32'd64);
        end

        // Realignment after 5 garbage bits
        send_word(16'hF800, 16'h0000, 15, 11, 1'b0, 1'b0, '0, '0);
        repeat (6) @(negedge bclk);
        align_i = 1'b1;
        @(negedge bclk);
        align_i = 1'b0;
        send_word(16'h1234, 16'hEDCB, DW - 1, 0, 1'b0, 1'b1, 16'h1234, 16'hEDCB);
        wait_empty("align_drain", 20);

        // Timeout after 7 bits: partial dropped, last word retained
        send_word(16'hFFFF, 16'hFFFF, 15, 9, 1'b0, 1'b0, '0, '0);
        @(negedge bclk);
        dclk = 1'b0;
        repeat (50) @(negedge bclk);
        chk("still_active", 32'(active_o), 32'd1);
        repeat (40) @(negedge bclk);
        chk("timeout_active", 32'(active_o), 32'd0);
        chk("timeout_keep_l", 32'(ldata_o), 32'h1234);
        chk("timeout_keep_r", 32'(rdata_o), 32'hEDCB);
        send_word(16'hBEEF, 16'h4110, DW - 1, 0, 1'b0, 1'b1, 16'hBEEF, 16'h4110);
        wait_empty("restart_drain", 20);
        chk("restart_active", 32'(active_o), 32'd1);

        // Reset during bit 9 of a word
        send_word(16'h0F0F, 16'hF0F0, 15, 8, 1'b0, 1'b0, '0, '0);
        @(negedge bclk);
        dclk  = 1'b0;
        ldata = 1'b1;
        @(negedge bclk);
        rst = 1'b1;
        @(negedge bclk);
        rst = 1'b0;
        chk("mid_rst_ldata", 32'(ldata_o), 32'd0);
        chk("mid_rst_rdata", 32'(rdata_o), 32'd0);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_active", 32'(active_o), 32'd0);
        repeat (4) @(negedge bclk);
        send_word(16'h5555, 16'hAAAA, DW - 1, 0, 1'b0, 1'b1, 16'h5555, 16'hAAAA);
        wait_empty("post_rst_drain", 20);

        // Slow, jittered dclk (~bclk/10) with random words
        vt.delete();
        for (int i = 3; i < 7; i++) begin
            send_word(vecs[i].l, vecs[i].r, DW - 1, 0, vecs[i].jit, 1'b1,
                      vecs[i].exp_l, vecs[i].exp_r);
        end
        wait_empty("slow_drain", 30);
        chk("slow_count", 32'(vt.size()), 32'd4);

        repeat (4) @(negedge bclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
